// File: rtl/rule_serializer.sv
// Rule-ID serializer: unpacks 8-slot rule beats into one rule ID per cycle.
// Empty packets yield a single zero marker with last set.
module rule_serializer #(
  parameter int RULE_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [127:0]  in_usr_data,
  input  logic          in_usr_valid,
  input  logic          in_usr_sop,
  input  logic          in_usr_eop,
  input  logic [3:0]    in_usr_empty,
  output logic          in_usr_ready,
  output logic [RULE_W-1:0] out_rule_id,
  output logic          out_rule_valid,
  output logic          out_rule_last,
  input  logic          out_rule_ready,
  output logic [31:0]   rule_cnt,
  output logic [31:0]   pkt_cnt,
  output logic [31:0]   nomatch_cnt
);

  localparam int NS = 128 / RULE_W;
  localparam int IW = $clog2(NS);

  logic [127:0]  hold_data;
  logic [NS-1:0] hold_mask;
  logic          hold_eop;
  logic          hold_valid;
  logic          pkt_has_rule;

  logic [NS-1:0] in_mask;
  logic [NS-1:0] sel_oh;
  logic [NS-1:0] mask_left;
  logic [IW-1:0] sel_idx;
  logic          mask_multi;
  logic          fire;
  logic          accept;
  logic          load;
  logic          unused_in;

  assign unused_in = ^{in_usr_sop, in_usr_empty};

  always_comb begin
    in_mask = '0;
    for (int i = 0; i < NS; i++)
      in_mask[i] = |in_usr_data[i*RULE_W +: RULE_W];
  end

  // Priority encoder: the lowest set slot wins.
  always_comb begin
    sel_idx = '0;
    for (int i = NS - 1; i >= 0; i--)
      if (hold_mask[i]) sel_idx = IW'(i);
  end

  assign sel_oh     = hold_mask & (~hold_mask + NS'(1));
  assign mask_left  = hold_mask & ~sel_oh;
  assign mask_multi = |(hold_mask & (hold_mask - NS'(1)));

  assign out_rule_valid = hold_valid;
  assign out_rule_id    = (hold_valid && hold_mask != '0)
                          ? hold_data[sel_idx*RULE_W +: RULE_W]
                          : '0;
  assign out_rule_last  = hold_valid & hold_eop & ~mask_multi;

  assign fire   = out_rule_valid & out_rule_ready;
  assign in_usr_ready = rst_n & (~hold_valid | (fire & ~mask_multi));
  assign accept = in_usr_valid & in_usr_ready;
  // Empty non-eop beats are swallowed without occupying the holder.
  assign load   = accept & ((|in_mask) | in_usr_eop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_data    <= '0;
      hold_mask    <= '0;
      hold_eop     <= 1'b0;
      hold_valid   <= 1'b0;
      pkt_has_rule <= 1'b0;
      rule_cnt     <= '0;
      pkt_cnt      <= '0;
      nomatch_cnt  <= '0;
    end else begin
      if (fire) begin
        hold_mask <= mask_left;
        if (mask_left == '0) hold_valid <= 1'b0;
      end
      if (load) begin
        hold_data  <= in_usr_data;
        hold_mask  <= in_mask;
        hold_eop   <= in_usr_eop;
        hold_valid <= 1'b1;
      end
      if (fire && out_rule_last)
        pkt_has_rule <= 1'b0;
      else if (fire && hold_mask != '0)
        pkt_has_rule <= 1'b1;
      if (fire && hold_mask != '0)
        rule_cnt <= rule_cnt + 32'd1;
      if (fire && out_rule_last)
        pkt_cnt <= pkt_cnt + 32'd1;
      // A zero after emitted rules is only a terminator, not a no-match.
      if (fire && hold_mask == '0 && !pkt_has_rule)
        nomatch_cnt <= nomatch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_rule_serializer.sv
// Scoreboard bench for rule_serializer: a packet-level model queues the
// expected rule stream; a negedge monitor pops and compares each output.
module tb_rule_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_usr_data;
  logic         in_usr_valid;
  logic         in_usr_sop;
  logic         in_usr_eop;
  logic [3:0]   in_usr_empty;
  logic         in_usr_ready;
  logic [15:0]  out_rule_id;
  logic         out_rule_valid;
  logic         out_rule_last;
  logic         out_rule_ready = 1'b1;
  logic [31:0]  rule_cnt;
  logic [31:0]  pkt_cnt;
  logic [31:0]  nomatch_cnt;

  rule_serializer #(.RULE_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_usr_data(in_usr_data), .in_usr_valid(in_usr_valid),
    .in_usr_sop(in_usr_sop), .in_usr_eop(in_usr_eop),
    .in_usr_empty(in_usr_empty), .in_usr_ready(in_usr_ready),
    .out_rule_id(out_rule_id), .out_rule_valid(out_rule_valid),
    .out_rule_last(out_rule_last), .out_rule_ready(out_rule_ready),
    .rule_cnt(rule_cnt), .pkt_cnt(pkt_cnt), .nomatch_cnt(nomatch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] id;
    logic        last;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_rule = 0;
  logic [31:0] exp_pkt = 0;
  logic [31:0] exp_nm = 0;
  int          pkt_rules = 0;
  int          rdy_pct = 100;
  bit          pat[$];
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Packet-level reference: nonzero slots in order, marker for empty packets.
  function automatic void model_beat(logic [127:0] d, bit eop);
    logic [15:0] ids[$];
    for (int i = 0; i < 8; i++)
      if (d[i*16 +: 16] != 16'h0) ids.push_back(d[i*16 +: 16]);
    foreach (ids[k])
      q.push_back(exp_t'{ids[k], eop && (k == ids.size() - 1)});
    exp_rule += ids.size();
    pkt_rules += ids.size();
    if (eop) begin
      if (ids.size() == 0) begin
        q.push_back(exp_t'{16'h0, 1'b1});
        if (pkt_rules == 0) exp_nm++;
      end
      exp_pkt++;
      pkt_rules = 0;
    end
  endfunction

  always @(posedge clk) begin
    #2;
    if (pat.size() > 0) out_rule_ready = pat.pop_front();
    else out_rule_ready = ($urandom_range(99) < rdy_pct);
  end

  bit          have_prev = 0;
  logic [15:0] prev_id;
  logic        prev_last;
  bit          mfire;
  bit          exp_rdy;
  exp_t        e;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      have_prev = 0;
    end else begin
      mfire = out_rule_valid && out_rule_ready;
      chk("out_valid", 32'(out_rule_valid), 32'(q.size() != 0));
      exp_rdy = (q.size() == 0) || (q.size() == 1 && mfire);
      chk("in_ready", 32'(in_usr_ready), 32'(exp_rdy));
      if (have_prev) begin
        chk("stall_valid", 32'(out_rule_valid), 32'd1);
        chk("stall_id", 32'(out_rule_id), 32'(prev_id));
        chk("stall_last", 32'(out_rule_last), 32'(prev_last));
      end
      if (mfire) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(out_rule_id), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("rule_id", 32'(out_rule_id), 32'(e.id));
          chk("rule_last", 32'(out_rule_last), 32'(e.last));
        end
      end
      have_prev = out_rule_valid && !out_rule_ready;
      prev_id   = out_rule_id;
      prev_last = out_rule_last;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send(logic [127:0] d, bit eop);
    in_usr_data  = d;
    in_usr_eop   = eop;
    in_usr_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      #1;
      if (in_usr_ready) begin
        model_beat(d, eop);
        @(posedge clk);
        #1;
        in_usr_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("send_timeout", 32'd1, 32'd0);
    in_usr_valid = 1'b0;
  endtask

  task automatic drain_and_count(string tag);
    int t;
    for (t = 0; t < 500; t++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) break;
    end
    if (t == 500) chk({tag, "_drain"}, 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_rule_cnt"}, rule_cnt, exp_rule);
    chk({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
    chk({tag, "_nomatch_cnt"}, nomatch_cnt, exp_nm);
  endtask

  logic [127:0] d;
  int           t0;

  initial begin
    rst_n = 1'b0;
    in_usr_data = '0;
    in_usr_valid = 1'b0;
    in_usr_sop = 1'b0;
    in_usr_eop = 1'b0;
    in_usr_empty = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_rule_valid), 32'd0);
    chk("rst_out_last", 32'(out_rule_last), 32'd0);
    chk("rst_out_id", 32'(out_rule_id), 32'd0);
    chk("rst_in_ready", 32'(in_usr_ready), 32'd0);
    chk("rst_rule_cnt", rule_cnt, 32'd0);
    chk("rst_pkt_cnt", pkt_cnt, 32'd0);
    chk("rst_nomatch_cnt", nomatch_cnt, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    d = '0;
    d[15:0] = 16'h0005;
    d[47:32] = 16'h0012;
    d[127:112] = 16'h1FFF;
    send(d, 1'b1);
    drain_and_count("single");

    send('0, 1'b0);
    send('0, 1'b1);
    drain_and_count("nomatch");

    d = '0;
    d[127:112] = 16'h0007;
    send(d, 1'b0);
    send('0, 1'b1);
    drain_and_count("terminator");

    d = '0;
    d[31:16] = 16'h0101;
    d[63:48] = 16'h0202;
    d[111:96] = 16'h0303;
    send(d, 1'b1);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    d = '0;
    d[15:0] = 16'h0404;
    send(d, 1'b1);
    drain_and_count("backpressure");

    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      d = '0;
      d[15:0] = 16'(k + 16'h0A0);
      send(d, 1'b1);
    end
    chk("b2b_cycles", 32'(cyc - t0), 32'd10);
    drain_and_count("b2b");

    d = '0;
    d[15:0] = 16'h0011;
    d[31:16] = 16'h0022;
    d[47:32] = 16'h0033;
    d[63:48] = 16'h0044;
    send(d, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    exp_rule = 0;
    exp_pkt = 0;
    exp_nm = 0;
    pkt_rules = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_out_valid", 32'(out_rule_valid), 32'd0);
    chk("midrst_rule_cnt", rule_cnt, 32'd0);
    chk("midrst_pkt_cnt", pkt_cnt, 32'd0);
    d = '0;
    d[15:0] = 16'h0003;
    send(d, 1'b1);
    drain_and_count("after_rst");

    rdy_pct = 70;
    for (int n = 0; n < 300; n++) begin
      d = '0;
      for (int i = 0; i < 8; i++)
        if ($urandom_range(3) == 0)
          d[i*16 +: 16] = 16'($urandom_range(65535, 1));
      send(d, $urandom_range(2) == 0);
      if ($urandom_range(4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    send('0, 1'b1);
    drain_and_count("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rule_serializer.md
# rule_serializer

Consumer-side counterpart of the port-group rule stream. Accepts the 128-bit packet stream of eight 16-bit rule-ID slots emitted by the port-group rule FIFO, where zero marks a discarded slot. Drops empty slots and emits surviving rule IDs one per cycle, in slot order, with a per-packet last flag. A packet with no surviving rules produces a single no-match marker. Sits between the port-group FIFO output and the rule-checking / reporting stage.

## Interface
- RULE_W, 16: rule-ID slot width; 128/RULE_W = 8 slots per beat.
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- in_usr_data  in  128  rule slots; slot i = bits [16i+15:16i], slot 0 first.
- in_usr_valid  in  1  beat valid.
- in_usr_sop  in  1  start of packet; ignored.
- in_usr_eop  in  1  end of packet.
- in_usr_empty  in  4  ignored; always 0 upstream.
- in_usr_ready  out  1  beat accepted when valid & ready.
- out_rule_id  out  16  rule ID; 0 = no-match marker.
- out_rule_valid  out  1  output valid.
- out_rule_last  out  1  last output of the packet.
- out_rule_ready  in  1  downstream accept.
- rule_cnt  out  32  nonzero rule IDs emitted.
- pkt_cnt  out  32  packets completed (eop output handshakes).
- nomatch_cnt  out  32  no-match markers emitted.

## Operation
- Holding register: hold_data[127:0], hold_mask[7:0] (bit i = slot i nonzero), hold_eop, hold_valid.
- pkt_has_rule flag: set on any emitted nonzero ID; cleared on the handshake that carries out_rule_last.
- Accept (valid & ready):
  - mask != 0: load the holding register.
  - mask == 0 and eop: load with hold_mask = 0; becomes a marker candidate.
  - mask == 0 and not eop: discard; no load, no output.
- Output selection: lowest set bit of hold_mask, via priority encoder. out_rule_id is that slot.
- out_rule_last = hold_eop and this is the only remaining mask bit.
- Each output handshake clears the selected bit. The holding register frees when the mask reaches 0 after a handshake.
- Eop beat with hold_mask = 0:
  - pkt_has_rule = 0: emit out_rule_id = 0 with out_rule_last = 1, once.
  - pkt_has_rule = 1: only possible if the previous beat already carried the final rule. Emit out_rule_id = 0, last = 1 as a terminator. Do not count it in nomatch_cnt; pkt_cnt still increments.
- in_usr_ready = rst_n & (!hold_valid | (out_rule_valid & out_rule_ready & remaining mask has ≤1 bit)). This allows back-to-back beats without a bubble.
- Counters are 32-bit and wrap modulo 2^32.

## Timing
- Reset (rst_n = 0 at a clk edge): hold_valid = 0, out_rule_valid = 0, out_rule_last = 0, out_rule_id = 0, in_usr_ready = 0, all counters = 0, pkt_has_rule = 0.
  - Reset mid-packet drops the held beat and packet state; no last is emitted.
- Latency: beat accepted at edge N gives its first output valid in cycle N+1.
- Throughput: one rule per cycle while out_rule_ready = 1. A beat with k nonzero slots holds the input for k cycles.
- Discarded empty non-eop beats consume one cycle each and keep ready high.
- Stall: out_rule_valid, id and last are held stable while out_rule_ready = 0; hold_mask is unchanged.
- Simultaneous final handshake and new accept: the holding register reloads with the new beat in the same edge; the next beat's output is in the following cycle.

## Test plan
- Single beat, eop, slots = {0x0005, 0, 0x0012, 0, 0, 0, 0, 0x1FFF}, ready = 1 -> outputs 0x0005, 0x0012, 0x1FFF on consecutive cycles, last only on 0x1FFF; rule_cnt = 3, pkt_cnt = 1.
- Two-beat packet: beat 0 all zero (no eop), beat 1 all zero with eop -> single output id = 0, last = 1; nomatch_cnt = 1, rule_cnt = 0.
- Beat 0 = {0x0007 in slot 7, no eop}, beat 1 = zeros with eop -> outputs 0x0007 (last = 0) then 0 (last = 1); nomatch_cnt = 0, pkt_cnt = 1.
- Back-pressure: out_rule_ready toggles 1,0,0,1 on a 3-rule beat -> each ID held stable through the stall; in_usr_ready = 0 until the final handshake; no loss or duplication.
- Back-to-back packets, each eop with one rule in slot 0, ready = 1, ten packets -> one output per cycle with no bubbles, all last = 1, pkt_cnt = 10.
- Reset asserted mid-beat (2 of 4 rules emitted) -> next cycle out_rule_valid = 0, counters = 0; following packet {0x0003, eop} -> 0x0003 with last = 1.
